mem_initiator: RTL

- Requester-side sequencer for the 2×256-byte word memory model (windows 0x0000_00xx and 0x8000_00xx).
- Accepts single-word load/store/fetch requests from the CPU datapath over a valid/ready handshake.
- Drives the memory's address, write-data, read-strobe and write-strobe pins in a glitch-safe setup/strobe/release order.
- Samples read data after a fixed wait and returns a response with an error flag for out-of-window addresses, so the memory never sees an illegal access.

---
 rtl/mem_initiator_pkg.sv | 24 ++
 rtl/mem_addr_decode.sv | 25 ++
 rtl/mem_initiator.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared constants for the memory initiator: word width, default window
// decode values and FSM state encodings.
package mem_initiator_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_WIN0_BASE = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_WIN1_BASE = 32'h8000_0000;
  localparam logic [WORD_W-1:0] DEF_WIN_MASK  = 32'hFFFF_FF00;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;
  localparam state_t RESP   = 2'd3;

  function automatic logic inWindow(input logic [WORD_W-1:0] addr,
                                    input logic [WORD_W-1:0] base,
                                    input logic [WORD_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational window check for the initiator. With MEMIF_ALIGN_CHECK_EN
// defined, non-word-aligned addresses are also reported as out of range.
module mem_addr_decode
  import mem_initiator_pkg::*;
#(
  parameter logic [WORD_W-1:0] WIN0_BASE = DEF_WIN0_BASE,
  parameter logic [WORD_W-1:0] WIN1_BASE = DEF_WIN1_BASE,
  parameter logic [WORD_W-1:0] WIN_MASK  = DEF_WIN_MASK
) (
  input  logic [WORD_W-1:0] addr,
  output logic              inRange
);

  logic winHit;

  assign winHit = inWindow(addr, WIN0_BASE, WIN_MASK) ||
                  inWindow(addr, WIN1_BASE, WIN_MASK);

`ifdef MEMIF_ALIGN_CHECK_EN
  assign inRange = winHit && (addr[1:0] == 2'b00);
`else
  assign inRange = winHit;
`endif

endmodule

// File: rtl/mem_initiator.sv
// Requester-side sequencer: one word access per request, driven as
// setup / strobe / release. Optional MEMIF_ALIGN_CHECK_EN rejects misaligned addresses.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int                WAIT_CYCLES = 2,
  parameter logic [WORD_W-1:0] WIN0_BASE   = DEF_WIN0_BASE,
  parameter logic [WORD_W-1:0] WIN1_BASE   = DEF_WIN1_BASE,
  parameter logic [WORD_W-1:0] WIN_MASK    = DEF_WIN_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t        stateReg;
  logic          writeLat;
  logic [CW-1:0] waitCnt;
  logic          inRange;

  mem_addr_decode #(
    .WIN0_BASE(WIN0_BASE),
    .WIN1_BASE(WIN1_BASE),
    .WIN_MASK (WIN_MASK)
  ) uDecode (
    .addr   (req_addr),
    .inRange(inRange)
  );

  assign req_ready = (stateReg == IDLE);
  assign rsp_valid = (stateReg == RESP);

  // Strobes are registered so they drop with reset and only ever change one
  // edge after the address was set up (or before it can change again).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      writeLat  <= 1'b0;
      waitCnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req_valid) begin
            writeLat  <= req_write;
            rsp_rdata <= '0;
            if (inRange) begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              rsp_err   <= 1'b0;
              stateReg  <= SETUP;
            end else begin
              // Illegal access never reaches the memory pins.
              rsp_err  <= 1'b1;
              stateReg <= RESP;
            end
          end
        end
        SETUP: begin
          waitCnt   <= CW'(WAIT_CYCLES - 1);
          mem_read  <= !writeLat;
          mem_write <= writeLat;
          stateReg  <= ACCESS;
        end
        ACCESS: begin
          if (waitCnt == '0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_rdata <= writeLat ? '0 : mem_rdata;
            stateReg  <= RESP;
          end else begin
            waitCnt <= waitCnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule
